// File: rtl/sk_adder_pipe.sv
// Pipelined Sklansky prefix adder, WIDTH power of two, STAGES register cuts inside the tree.
// Latency STAGES+2 cycles; the whole pipe advances only when the output slot is empty or being consumed.
// Backpressure: in_ready = !out_valid || out_ready. Optional signed overflow output under SK_ADDER_OVF_EN.
module sk_adder_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SK_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int L = $clog2(WIDTH);

  // True when one of the STAGES cuts lands right after prefix level lvl.
  function automatic bit is_cut(input int lvl);
    bit r;
    r = 1'b0;
    for (int k = 1; k <= STAGES; k++) begin
      if ((k * L) / (STAGES + 1) == lvl) r = 1'b1;
    end
    return r;
  endfunction

  logic en;
  logic out_vld_q, out_vld_d;

  assign en       = !out_vld_q || out_ready;
  assign in_ready = en;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d, in_vld_q, in_vld_d;

  always_comb begin
    a_d      = a;
    b_d      = b;
    cin_d    = cin;
    in_vld_d = in_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      in_vld_q <= 1'b0;
    end else if (en) begin
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      in_vld_q <= in_vld_d;
    end
  end

  for (genvar lvl = 0; lvl <= L; lvl++) begin : g_lvl
    logic [WIDTH-1:0] g_c, p_c, pz_c, g_s, p_s, pz_s;
    logic             cin_c, vld_c, cin_s, vld_s;

    if (lvl == 0) begin : g_form
      // cin enters as a bit -1 generate, absorbed into the bit 0 generate term.
      always_comb begin
        p_c    = a_q ^ b_q;
        g_c    = a_q & b_q;
        g_c[0] = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & cin_q);
        pz_c   = a_q ^ b_q;
        cin_c  = cin_q;
        vld_c  = in_vld_q;
      end
    end else begin : g_pfx
      always_comb begin
        g_c   = g_lvl[lvl-1].g_s;
        p_c   = g_lvl[lvl-1].p_s;
        pz_c  = g_lvl[lvl-1].pz_s;
        cin_c = g_lvl[lvl-1].cin_s;
        vld_c = g_lvl[lvl-1].vld_s;
        for (int j = 0; j < WIDTH; j++) begin
          if (((j >> (lvl - 1)) & 1) == 1) begin
            g_c[j] = g_lvl[lvl-1].g_s[j] |
                     (g_lvl[lvl-1].p_s[j] & g_lvl[lvl-1].g_s[(j & ~((1 << (lvl - 1)) - 1)) - 1]);
            p_c[j] = g_lvl[lvl-1].p_s[j] & g_lvl[lvl-1].p_s[(j & ~((1 << (lvl - 1)) - 1)) - 1];
          end
        end
      end
    end

    if (is_cut(lvl)) begin : g_cut
      logic [WIDTH-1:0] g_q, g_d, p_q, p_d, pz_q, pz_d;
      logic             c_q, c_d, v_q, v_d;

      always_comb begin
        g_d  = g_c;
        p_d  = p_c;
        pz_d = pz_c;
        c_d  = cin_c;
        v_d  = vld_c;
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          g_q  <= '0;
          p_q  <= '0;
          pz_q <= '0;
          c_q  <= 1'b0;
          v_q  <= 1'b0;
        end else if (en) begin
          g_q  <= g_d;
          p_q  <= p_d;
          pz_q <= pz_d;
          c_q  <= c_d;
          v_q  <= v_d;
        end
      end

      assign g_s   = g_q;
      assign p_s   = p_q;
      assign pz_s  = pz_q;
      assign cin_s = c_q;
      assign vld_s = v_q;
    end else begin : g_thru
      assign g_s   = g_c;
      assign p_s   = p_c;
      assign pz_s  = pz_c;
      assign cin_s = cin_c;
      assign vld_s = vld_c;
    end
  end

  // Group propagate of the last level has no consumer.
  logic unused_p;
  assign unused_p = ^g_lvl[L].p_s;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  // After the last level G[i] is the carry out of bit i; carry into bit 0 is cin.
  always_comb begin
    sum_d     = g_lvl[L].pz_s ^ {g_lvl[L].g_s[WIDTH-2:0], g_lvl[L].cin_s};
    cout_d    = g_lvl[L].g_s[WIDTH-1];
    out_vld_d = g_lvl[L].vld_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q     <= '0;
      cout_q    <= 1'b0;
      out_vld_q <= 1'b0;
    end else if (en) begin
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_vld_q;

`ifdef SK_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_comb begin
    ovf_d = g_lvl[L].g_s[WIDTH-1] ^ g_lvl[L].g_s[WIDTH-2];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_sk_adder_pipe.sv
// Scoreboard bench for sk_adder_pipe: four configurations run in parallel, each with its
// own driver, reference queue and monitor; a shared summary closes the run.
module tb_sk_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: plain integer addition at width w, returned as {ovf, cout, sum}.
  function automatic logic [65:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic c, input int w);
    logic [64:0] full;
    logic [63:0] mask;
    logic [63:0] xm, ym;
    logic        o;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    xm   = x & mask;
    ym   = y & mask;
    full = {1'b0, xm} + {1'b0, ym} + {64'd0, c};
    o    = 1'b0;
`ifdef SK_ADDER_OVF_EN
    o = (xm[w-1] == ym[w-1]) && (full[w-1] != xm[w-1]);
`endif
    return {o, full[w], full[63:0] & mask};
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
    localparam int W = (gi < 2) ? 64 : 8;
    localparam int S = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 0 : 3;
    localparam int D = S + 2;

    logic         rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf_act;
    logic [W-1:0] a, b, sum;
    logic [65:0]  exp_q[$];

`ifdef SK_ADDER_OVF_EN
    logic ovf;
    assign ovf_act = ovf;
`else
    assign ovf_act = 1'b0;
`endif

    sk_adder_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
`ifdef SK_ADDER_OVF_EN
      .cout      (cout),
      .ovf       (ovf)
`else
      .cout      (cout)
`endif
    );

    function automatic logic [W-1:0] rnd_op();
      logic [63:0] r;
      int          sel;
      sel = $urandom_range(0, 9);
      r   = {$urandom(), $urandom()};
      if (sel == 0) r = 64'd0;
      if (sel == 1) r = 64'hFFFF_FFFF_FFFF_FFFF;
      return r[W-1:0];
    endfunction

    task automatic beat(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic ordy);
      @(posedge clk);
      #1;
      in_valid  = v;
      a         = x;
      b         = y;
      cin       = c;
      out_ready = ordy;
      @(negedge clk);
      if (v && in_ready) exp_q.push_back(model(64'(x), 64'(y), c, W));
    endtask

    task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
        beat(1'b0, '0, '0, 1'b0, 1'b1);
        n++;
      end
      chk($sformatf("cfg%0d %s drain_left", gi, tag), exp_q.size(), 0);
    endtask

    task automatic latency_probe(input string tag);
      int           t_acc, n;
      logic [W-1:0] ones;
      ones = '1;
      beat(1'b1, ones, '0, 1'b1, 1'b1);
      t_acc = cyc;
      n = 0;
      do begin
        beat(1'b0, '0, '0, 1'b0, 1'b1);
        n++;
      end while (!out_valid && n < 20);
      chk($sformatf("cfg%0d %s latency", gi, tag), cyc - t_acc, D);
      chk($sformatf("cfg%0d %s wrap_sum_cout", gi, tag), {cout, 64'(sum)}, {1'b1, 64'd0});
      drain(tag);
    endtask

    always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
        chk($sformatf("cfg%0d result_expected", gi), exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0)
          chk($sformatf("cfg%0d result", gi), {ovf_act, cout, 64'(sum)}, exp_q.pop_front());
      end
    end

    initial begin
      logic [W-1:0] m, x, y;
      logic [W-1:0] s_hold;
      logic         c_hold;
      int           nb;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk($sformatf("cfg%0d reset out_valid", gi), out_valid, 0);
      chk($sformatf("cfg%0d reset sum", gi), 64'(sum), 0);
      chk($sformatf("cfg%0d reset cout", gi), cout, 0);
      chk($sformatf("cfg%0d reset in_ready", gi), in_ready, 1);

      latency_probe("first");

      // Signed-overflow corners, also exact sum/cout checks at any build.
      m = '1;
      x = m >> 1;
      beat(1'b1, x, W'(1), 1'b0, 1'b1);
      x = ~(m >> 1);
      beat(1'b1, x, m, 1'b0, 1'b1);
      y = m - W'(4);
      beat(1'b1, W'(5), y, 1'b0, 1'b1);
      drain("ovf");

      nb = (gi >= 2) ? 1500 : 1000;
      for (int i = 0; i < nb; i++) begin
        beat(1'b1, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'b1);
        if (in_ready !== 1'b1) chk($sformatf("cfg%0d burst in_ready", gi), in_ready, 1);
      end
      chk($sformatf("cfg%0d burst in_ready end", gi), in_ready, 1);
      drain("burst");

      for (int i = 0; i < 400; i++)
        beat(1'($urandom_range(0, 3) != 0), rnd_op(), rnd_op(), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 2) != 0));
      drain("mix");

      for (int i = 0; i < D; i++)
        beat(1'b1, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'b1);
      for (int i = 0; i < 5; i++) begin
        beat(1'b1, rnd_op(), rnd_op(), 1'b1, 1'b0);
        if (i == 0) begin
          s_hold = sum;
          c_hold = cout;
        end
        chk($sformatf("cfg%0d stall in_ready", gi), in_ready, 0);
        chk($sformatf("cfg%0d stall out_valid", gi), out_valid, 1);
        chk($sformatf("cfg%0d stall sum_cout", gi), {cout, 64'(sum)}, {c_hold, 64'(s_hold)});
      end
      drain("stall");

      for (int i = 0; i < 3; i++)
        beat(1'b1, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk($sformatf("cfg%0d midreset out_valid", gi), out_valid, 0);
      chk($sformatf("cfg%0d midreset sum", gi), 64'(sum), 0);
      for (int i = 0; i < 2 * D; i++) beat(1'b0, '0, '0, 1'b0, 1'b1);
      latency_probe("after_reset");

      chk($sformatf("cfg%0d final queue", gi), exp_q.size(), 0);
      done_cnt++;
    end
  end

  initial begin
    while (done_cnt < 4 && cyc < 30000) @(posedge clk);
    checks++;
    if (done_cnt < 4) begin
      errors++;
      $display("FAIL timeout done=%0d required=4", done_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sk_adder_pipe.md
# sk_adder_pipe

Parametrised, pipelined Sklansky parallel-prefix adder with valid/ready flow control. Generalises the fixed 64-bit, registered-in/registered-out adder timing wrapper to any power-of-two width, with a selectable number of register cuts inside the prefix tree and backpressure support. Intended as the arithmetic core for datapaths where the adder must close timing at high clock rates and sit between handshaked producers and consumers.

## Interface
- WIDTH, 64: operand/sum width. Power of two, at least 2. L = clog2(WIDTH) prefix levels.
- STAGES, 1: register cuts inside the prefix tree, range 0..L.
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  operand A, unsigned (two's complement when overflow is enabled).
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result this cycle.
- sum  out  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow. Present only with SK_ADDER_OVF_EN.

## Operation
- Datapath: input register, then generate/propagate formation, L Sklansky prefix levels, sum XOR, then output register. Level i combines every bit position with the group ending at the last bit of the preceding 2^i-aligned block. cin is folded in as the bit -1 generate term.
- Internal cuts: for k = 1..STAGES, a register bank is placed after prefix level floor(k*L/(STAGES+1)). Each bank carries G/P for the full width, the original propagate bits, and the valid bit.
- Pipeline depth is D = STAGES + 2 register banks. Each bank has its own valid bit.
- Flow control uses a single global advance: en = !out_valid || out_ready.
  - in_ready = en.
  - All banks load only when en = 1.
  - A bank's valid bit loads the upstream valid value, which is in_valid for the first bank.
  - Bubbles are not collapsed: the pipeline advances as a unit.
- A beat is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
- Results leave in acceptance order. None is dropped or duplicated.
- While stalled (en = 0), sum, cout, ovf and out_valid hold their values.
- Arithmetic is exact modulo 2^WIDTH. cout equals bit WIDTH of the full-width sum.

## Timing
- Reset (rst_n low at a rising edge):
  - All valid bits are cleared. out_valid = 0.
  - sum = 0, cout = 0, ovf = 0. All internal data registers are cleared.
  - in_ready is 1 in the cycle after reset.
- Reset mid-operation discards all in-flight beats. No result of a pre-reset beat is ever presented afterwards.
- Latency: a beat accepted at edge t appears with out_valid = 1 after edge t + D - 1 when no stall occurs. Example: D = 3 for STAGES = 1, so the result is valid from cycle t+2.
- Throughput: one beat per cycle while out_ready is held at 1.
- Simultaneous consume and accept in the same cycle is legal and sustains full rate.
- When out_valid = 0, in_ready = 1 regardless of out_ready.
- in_ready depends combinationally on out_valid and out_ready only. There is no combinational path from a, b, cin or in_valid to any output.

## Configuration
- SK_ADDER_OVF_EN defined:
  - Port ovf exists.
  - ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]), where W = WIDTH.
  - ovf is registered in the output bank with the same latency and stall behaviour as sum.
- SK_ADDER_OVF_EN undefined:
  - Port ovf and its logic are absent.
  - The remaining behaviour is identical.

## Test plan
- WIDTH=64, STAGES=1, out_ready=1: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 accepted at t.
  - Required: sum=0, cout=1, out_valid first high in cycle t+2.
- WIDTH=64, STAGES=2, out_ready=1: 1000 back-to-back random beats.
  - Required: in_ready constantly 1, one result per cycle after a 3-cycle fill, every result matching the reference model in order.
- Stall: fill the pipeline, then drop out_ready for 5 cycles.
  - Required: in_ready=0 and sum/cout stable for all 5 cycles, then in-order drain with no loss or duplication.
- Reset mid-stream: drive rst_n=0 for 1 cycle with 3 beats in flight.
  - Required: out_valid=0 and sum=0 after the edge; the 3 beats never appear; new beats resume with normal latency.
- WIDTH=8, STAGES=0 and STAGES=3: exhaustive a, b, cin (131072 vectors).
  - Required: all sums and couts exact.
- SK_ADDER_OVF_EN with WIDTH=64:
  - 0x7FFF…F + 1, cin=0 -> ovf=1.
  - 0x8000…0 + 0xFFFF…F -> ovf=1, cout=1.
  - 5 + 0xFFFF…FFFB -> ovf=0, sum=0, cout=1.
